// File: rtl/decode_ctrl_stage_if.sv
// Fetch-to-execute handshake and decoded control bundle for decode_ctrl_stage.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface decode_ctrl_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] instr_i;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            PCSel;
  logic [1:0]            ResultSel;
  logic                  MemWrite;
  logic [3:0]            ALUCtrl;
  logic                  ALUSel;
  logic [2:0]            ImmSel;
  logic                  RegWrite;
  logic                  Branch;
  logic [2:0]            MemCtrl;
  logic                  Mul;
  logic                  Illegal;
  logic                  m_busy;

  modport master (
    output instr_i, in_valid, flush, out_ready,
    input  in_ready, out_valid, PCSel, ResultSel, MemWrite, ALUCtrl, ALUSel,
           ImmSel, RegWrite, Branch, MemCtrl, Mul, Illegal, m_busy
  );

  modport slave (
    input  instr_i, in_valid, flush, out_ready,
    output in_ready, out_valid, PCSel, ResultSel, MemWrite, ALUCtrl, ALUSel,
           ImmSel, RegWrite, Branch, MemCtrl, Mul, Illegal, m_busy
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered RV32IM control decoder between fetch and execute, with valid/ready
// handshake, multi-cycle M-extension occupancy, flush and illegal-opcode flag.
module decode_ctrl_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 33
) (
  input  logic               clk,
  input  logic               rst,
  decode_ctrl_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic [1:0] result_sel;
    logic       mem_write;
    logic [3:0] alu_ctrl;
    logic       alu_sel;
    logic [2:0] imm_sel;
    logic       reg_write;
    logic       branch;
    logic [2:0] mem_ctrl;
    logic       mul;
    logic       illegal;
  } ctrl_t;

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            fields_q, fields_d;
  ctrl_t            dec;
  logic [CNT_W-1:0] dec_lat;
  logic             in_ready_c;

  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        unused_bits;

  assign instr       = bus.instr_i[31:0];
  assign op          = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  // Combinational decode of the incoming instruction; captured only on acceptance.
  always_comb begin
    dec          = '0;
    dec.mem_ctrl = f3;
    case (op)
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.result_sel = 2'b01;
        dec.alu_sel    = 1'b1;
        dec.imm_sel    = 3'b000;
        dec.alu_ctrl   = 4'b0000;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.imm_sel   = 3'b001;
        dec.alu_ctrl  = 4'b0000;
      end
      7'b0010011, 7'b0110011: begin
        if (op[5] && (f7 == 7'b0000001) && (ENABLE_M == 0)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_sel   = ~op[5];
          dec.alu_ctrl  = {f7[5] & ((f3 == 3'b101) | ((f3 == 3'b000) & op[5])), f3};
          dec.mul       = op[5] & (f7 == 7'b0000001);
        end
      end
      7'b1100011: begin
        dec.branch   = 1'b1;
        dec.imm_sel  = 3'b010;
        dec.alu_ctrl = {1'b0, f3};
      end
      7'b0110111, 7'b0010111: begin
        dec.reg_write  = 1'b1;
        dec.alu_sel    = 1'b1;
        dec.imm_sel    = 3'b011;
        dec.alu_ctrl   = 4'b1111;
        dec.result_sel = op[5] ? 2'b00 : 2'b01;
      end
      7'b1101111, 7'b1100111: begin
        dec.pc_sel     = op[3] ? 2'b01 : 2'b10;
        dec.imm_sel    = op[3] ? 3'b100 : 3'b000;
        dec.reg_write  = 1'b1;
        dec.result_sel = 2'b11;
        dec.alu_sel    = 1'b1;
        dec.alu_ctrl   = 4'b0010;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_lat = ONE;
    if (dec.mul) begin
      dec_lat = f3[2] ? DIV_LAT : MUL_LAT;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fields_d   = fields_q;
    in_ready_c = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_ready_c = 1'b1;
      end
      ST_WAIT: begin
        if (cnt_q == ONE) begin
          state_d = ST_FULL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_FULL: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready && !bus.in_valid) begin
          state_d  = ST_EMPTY;
          fields_d = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (in_ready_c && bus.in_valid) begin
      fields_d = dec;
      if (dec_lat == ONE) begin
        state_d = ST_FULL;
        cnt_d   = '0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = dec_lat - ONE;
      end
    end

    // Flush overrides everything: drop the held and the incoming instruction.
    if (bus.flush) begin
      in_ready_c = 1'b0;
      state_d    = ST_EMPTY;
      cnt_d      = '0;
      fields_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fields_q <= fields_d;
    end
  end

  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.m_busy    = (state_q == ST_WAIT);
  assign bus.PCSel     = fields_q.pc_sel;
  assign bus.ResultSel = fields_q.result_sel;
  assign bus.MemWrite  = fields_q.mem_write;
  assign bus.ALUCtrl   = fields_q.alu_ctrl;
  assign bus.ALUSel    = fields_q.alu_sel;
  assign bus.ImmSel    = fields_q.imm_sel;
  assign bus.RegWrite  = fields_q.reg_write;
  assign bus.Branch    = fields_q.branch;
  assign bus.MemCtrl   = fields_q.mem_ctrl;
  assign bus.Mul       = fields_q.mul;
  assign bus.Illegal   = fields_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: directed cases, randomized traffic, and
// an ENABLE_M=0 instance for the M-encoding illegal path.
module tb_decode_ctrl_stage;

  localparam int MULC = 3;
  localparam int DIVC = 33;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decode_ctrl_stage_if #(.DATA_WIDTH(32)) bus ();
  decode_ctrl_stage_if #(.DATA_WIDTH(32)) bus_nm ();

  decode_ctrl_stage #(
    .DATA_WIDTH(32), .ENABLE_M(1), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  decode_ctrl_stage #(
    .DATA_WIDTH(32), .ENABLE_M(0), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)
  ) dut_nm (
    .clk(clk), .rst(rst), .bus(bus_nm)
  );

  // Field bundle order: PCSel ResultSel MemWrite ALUCtrl ALUSel ImmSel RegWrite Branch MemCtrl Mul Illegal
  logic [19:0] got, got_nm;
  assign got = {bus.PCSel, bus.ResultSel, bus.MemWrite, bus.ALUCtrl, bus.ALUSel, bus.ImmSel,
                bus.RegWrite, bus.Branch, bus.MemCtrl, bus.Mul, bus.Illegal};
  assign got_nm = {bus_nm.PCSel, bus_nm.ResultSel, bus_nm.MemWrite, bus_nm.ALUCtrl, bus_nm.ALUSel,
                   bus_nm.ImmSel, bus_nm.RegWrite, bus_nm.Branch, bus_nm.MemCtrl, bus_nm.Mul,
                   bus_nm.Illegal};

  typedef struct {
    logic [31:0] instr;
    logic [19:0] fields;
    int          due;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] pack(input int pc, rs, mw, alu, asel, imm, rw, br, mc, mul, ill);
    return {2'(pc), 2'(rs), 1'(mw), 4'(alu), 1'(asel), 3'(imm), 1'(rw), 1'(br), 3'(mc),
            1'(mul), 1'(ill)};
  endfunction

  function automatic bit is_m_op(input logic [31:0] ins);
    return (ins[6:0] == 7'h33) && (ins[31:25] == 7'h01);
  endfunction

  function automatic logic [19:0] model(input logic [31:0] ins, input bit en_m);
    int f3  = int'(ins[14:12]);
    int alt = int'(ins[30]);
    case (ins[6:0])
      7'h03: return pack(0, 1, 0, 0, 1, 0, 1, 0, f3, 0, 0);
      7'h23: return pack(0, 0, 1, 0, 1, 1, 0, 0, f3, 0, 0);
      7'h13: return pack(0, 0, 0, ((f3 == 5) ? alt : 0) * 8 + f3, 1, 0, 1, 0, f3, 0, 0);
      7'h33: begin
        if (is_m_op(ins) && !en_m) return pack(0, 0, 0, 0, 0, 0, 0, 0, f3, 0, 1);
        return pack(0, 0, 0, ((f3 == 5 || f3 == 0) ? alt : 0) * 8 + f3, 0, 0, 1, 0, f3,
                    int'(is_m_op(ins)), 0);
      end
      7'h63: return pack(0, 0, 0, f3, 0, 2, 0, 1, f3, 0, 0);
      7'h37: return pack(0, 0, 0, 15, 1, 3, 1, 0, f3, 0, 0);
      7'h17: return pack(0, 1, 0, 15, 1, 3, 1, 0, f3, 0, 0);
      7'h6F: return pack(1, 3, 0, 2, 1, 4, 1, 0, f3, 0, 0);
      7'h67: return pack(2, 3, 0, 2, 1, 0, 1, 0, f3, 0, 0);
      default: return pack(0, 0, 0, 0, 0, 0, 0, 0, f3, 0, 1);
    endcase
  endfunction

  function automatic int latency(input logic [31:0] ins);
    if (!is_m_op(ins)) return 1;
    return ins[14] ? DIVC : MULC;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 11);
    case (k)
      0: r[6:0] = 7'h03;
      1: r[6:0] = 7'h23;
      2: r[6:0] = 7'h13;
      3: begin
        r[6:0] = 7'h33;
        r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      end
      4: begin
        r[6:0] = 7'h33;
        r[31:25] = 7'h01;
      end
      5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h17;
      8: r[6:0] = 7'h6F;
      9: r[6:0] = 7'h67;
      11: begin
        r[6:0] = 7'h33;
        r[31:25] = 7'h01;
        r[14] = 1'b0;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One cycle of stimulus; the expected response is queued once acceptance is seen.
  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.instr_i   = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else if (v && bus.in_ready) begin
      e.instr  = ins;
      e.fields = model(ins, 1'b1);
      e.due    = cyc + latency(ins);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Monitor: compares handshake state and held fields against the scoreboard every cycle.
  initial begin
    bit   prev_flush = 1'b0;
    bit   exp_ov, exp_busy, exp_ir;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_ov   = (sb.size() > 0) && (cyc >= sb[0].due);
        exp_busy = (sb.size() > 0) && (cyc < sb[0].due);
        exp_ir   = !bus.flush && ((sb.size() == 0) || (exp_ov && bus.out_ready));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("m_busy", 32'(bus.m_busy), 32'(exp_busy));
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (prev_flush) check("fields_after_flush", 32'(got), 32'h0);
        if (exp_ov && bus.out_valid) check("fields", 32'(got), 32'(sb[0].fields));
        if (exp_ov && bus.out_ready && !bus.flush) begin
          e = sb.pop_front();
          $display("[TB] retire instr=%08h fields=%05h cycle=%0d", e.instr, got, cyc);
        end
        prev_flush = bus.flush;
      end else begin
        prev_flush = 1'b0;
      end
    end
  end

  task automatic nm_test(input logic [31:0] ins);
    @(posedge clk);
    #1;
    bus_nm.in_valid = 1'b1;
    bus_nm.instr_i  = ins;
    @(negedge clk);
    check("nm_in_ready", 32'(bus_nm.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus_nm.in_valid = 1'b0;
    @(negedge clk);
    check("nm_out_valid", 32'(bus_nm.out_valid), 32'h1);
    check("nm_fields", 32'(got_nm), 32'(model(ins, 1'b0)));
    $display("[TB] nm instr=%08h fields=%05h cycle=%0d", ins, got_nm, cyc);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b1;  bus.instr_i = 32'h002081B3; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus_nm.in_valid = 1'b0; bus_nm.instr_i = 32'h0; bus_nm.out_ready = 1'b1; bus_nm.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_m_busy", 32'(bus.m_busy), 32'h0);
    check("rst_fields", 32'(got), 32'h0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    drive(1'b1, 32'h002081B3, 1'b1, 1'b0);               // ADD
    idle(2);
    drive(1'b1, 32'h402081B3, 1'b1, 1'b0);               // SUB
    drive(1'b1, 32'h4020D193, 1'b1, 1'b0);               // SRAI back-to-back
    idle(2);
    drive(1'b1, 32'h0220C1B3, 1'b1, 1'b0);               // DIV
    idle(DIVC + 2);
    drive(1'b1, 32'h022081B3, 1'b1, 1'b0);               // MUL
    idle(MULC + 2);
    drive(1'b1, 32'h0000A183, 1'b0, 1'b0);               // LW, then execute stalls
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0030A223, 1'b0, 1'b0);
    drive(1'b1, 32'h0030A223, 1'b1, 1'b0);               // SW accepted on release
    idle(2);
    drive(1'b1, 32'h0220C1B3, 1'b1, 1'b0);               // DIV, flushed mid-count
    idle(9);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(DIVC + 5);
    drive(1'b1, 32'h0000007F, 1'b1, 1'b0);               // illegal opcode
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 49) == 0));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(3);

    nm_test(32'h022081B3);                               // MUL with M disabled
    nm_test(32'h0220C1B3);                               // DIV with M disabled
    nm_test(32'h402081B3);                               // SUB still legal

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
